// File: rtl/uart_tx_rx_sched_if.sv
// Bundle of the sequencer's handshake and UART register-bus signals.
//   master : the sequencer (drives readies, rx holding register, bus outputs)
//   slave  : the environment (requesters, rx consumer, UART register file)
// Signals:
//   req0_valid/req0_data/req0_ready  requester 0 byte stream
//   req1_valid/req1_data/req1_ready  requester 1 byte stream
//   rx_valid/rx_data/rx_ready        received-byte holding register
//   init_done                        configuration writes issued
//   uart_wr_en/uart_addr/uart_wdata  UART register bus, one op per cycle
//   uart_rdata                       UART combinational read data
interface uart_tx_rx_sched_if;
  logic        req0_valid;
  logic [7:0]  req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [7:0]  req1_data;
  logic        req1_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        init_done;
  logic        uart_wr_en;
  logic [31:0] uart_addr;
  logic [31:0] uart_wdata;
  logic [31:0] uart_rdata;

  modport master (
    input  req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_rdata,
    output req0_ready, req1_ready, rx_valid, rx_data, init_done,
           uart_wr_en, uart_addr, uart_wdata
  );

  modport slave (
    output req0_valid, req0_data, req1_valid, req1_data, rx_ready, uart_rdata,
    input  req0_ready, req1_ready, rx_valid, rx_data, init_done,
           uart_wr_en, uart_addr, uart_wdata
  );
endinterface

// File: rtl/uart_tx_rx_sched.sv
// Bus-master sequencer for the memory-mapped UART. Configures CTRL and DIV
// after reset, then polls STATUS: pending RX bytes are read into a one-entry
// valid/ready holding register (and the rx flag cleared), otherwise the
// transmitter is shared between two requesters by round-robin.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset
//   sif    uart_tx_rx_sched_if.master (requesters, rx holding register,
//          init_done, UART register bus)
module uart_tx_rx_sched #(
  parameter int unsigned DIV_VAL = 434,
  parameter bit          RX_EN   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  uart_tx_rx_sched_if.master         sif
);

  localparam logic [31:0] ADDR_CTRL   = 32'h0;
  localparam logic [31:0] ADDR_STATUS = 32'h4;
  localparam logic [31:0] ADDR_DIV    = 32'h8;
  localparam logic [31:0] ADDR_TXDATA = 32'hC;
  localparam logic [31:0] ADDR_RXDATA = 32'h10;

  typedef enum logic [2:0] {
    S_INIT_CTRL,
    S_INIT_DIV,
    S_POLL,
    S_TX_WR,
    S_RX_RD,
    S_RX_CLR
  } state_t;

  state_t      state_q, state_d;
  logic        rr_q, rr_d;            // 0: req0 favoured, 1: req1 favoured
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        init_done_q, init_done_d;

  logic        rx_take;
  logic        grant0;
  logic        grant1;

  logic        unused_rdata;
  assign unused_rdata = ^sif.uart_rdata[31:8];

  // POLL decision from the STATUS value read this cycle; RX beats TX.
  always_comb begin
    rx_take = 1'b0;
    grant0  = 1'b0;
    grant1  = 1'b0;
    if (state_q == S_POLL) begin
      if (RX_EN && sif.uart_rdata[1] && !rx_valid_q) begin
        rx_take = 1'b1;
      end else if (!sif.uart_rdata[0]) begin
        if (sif.req0_valid && sif.req1_valid) begin
          grant0 = !rr_q;
          grant1 = rr_q;
        end else begin
          grant0 = sif.req0_valid;
          grant1 = sif.req1_valid;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_INIT_CTRL;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_INIT_CTRL: state_d = S_INIT_DIV;
      S_INIT_DIV:  state_d = S_POLL;
      S_POLL: begin
        if (rx_take)              state_d = S_RX_RD;
        else if (grant0 || grant1) state_d = S_TX_WR;
      end
      S_TX_WR:     state_d = S_POLL;
      S_RX_RD:     state_d = S_RX_CLR;
      S_RX_CLR:    state_d = S_POLL;
      default:     state_d = S_INIT_CTRL;
    endcase
  end

  // Bus and handshake outputs decoded from the state register; held at
  // their idle values while reset is asserted.
  always_comb begin
    sif.uart_wr_en = 1'b0;
    sif.uart_addr  = '0;
    sif.uart_wdata = '0;
    sif.req0_ready = 1'b0;
    sif.req1_ready = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_INIT_CTRL: begin
          sif.uart_wr_en = 1'b1;
          sif.uart_addr  = ADDR_CTRL;
          sif.uart_wdata = {30'b0, RX_EN, 1'b1};
        end
        S_INIT_DIV: begin
          sif.uart_wr_en = 1'b1;
          sif.uart_addr  = ADDR_DIV;
          sif.uart_wdata = 32'(DIV_VAL);
        end
        S_POLL: begin
          sif.uart_addr  = ADDR_STATUS;
          sif.req0_ready = grant0;
          sif.req1_ready = grant1;
        end
        S_TX_WR: begin
          sif.uart_wr_en = 1'b1;
          sif.uart_addr  = ADDR_TXDATA;
          sif.uart_wdata = {24'b0, tx_byte_q};
        end
        S_RX_RD: begin
          sif.uart_addr  = ADDR_RXDATA;
        end
        S_RX_CLR: begin
          sif.uart_wr_en = 1'b1;
          sif.uart_addr  = ADDR_STATUS;
        end
        default: ;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    rr_d        = rr_q;
    tx_byte_d   = tx_byte_q;
    rx_valid_d  = rx_valid_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    if (grant0) begin
      tx_byte_d = sif.req0_data;
      rr_d      = 1'b1;
    end else if (grant1) begin
      tx_byte_d = sif.req1_data;
      rr_d      = 1'b0;
    end
    if (rx_valid_q && sif.rx_ready) rx_valid_d = 1'b0;
    // RX_RD is only entered with rx_valid_q=0, so no clash with the clear.
    if (state_q == S_RX_RD) begin
      rx_valid_d = 1'b1;
      rx_data_d  = sif.uart_rdata[7:0];
    end
    if (state_q == S_INIT_DIV) init_done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      tx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      tx_byte_q   <= tx_byte_d;
      rx_valid_q  <= rx_valid_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
    end
  end

  assign sif.rx_valid  = rx_valid_q;
  assign sif.rx_data   = rx_data_q;
  assign sif.init_done = init_done_q;

endmodule

// File: tb/tb_uart_tx_rx_sched.sv
module tb_uart_tx_rx_sched;
  localparam int unsigned DIV    = 434;
  localparam bit          RXEN   = 1'b1;
  localparam int          BUSY_N = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_rx_sched_if sif ();

  uart_tx_rx_sched #(.DIV_VAL(DIV), .RX_EN(RXEN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .sif  (sif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- UART register-file stand-in ----------------
  int         tx_cnt = 0;
  bit         rx_full = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  bit         rx_inject = 1'b0;
  logic [7:0] rx_inject_byte = 8'h00;
  logic [7:0] tx_log[$];

  always @(posedge clk) begin
    if (sif.uart_wr_en && sif.uart_addr == 32'hC) begin
      tx_cnt <= BUSY_N;
      tx_log.push_back(sif.uart_wdata[7:0]);
    end else if (tx_cnt != 0) begin
      tx_cnt <= tx_cnt - 1;
    end
    if (sif.uart_wr_en && sif.uart_addr == 32'h4) begin
      rx_full <= 1'b0;
    end else if (rx_inject) begin
      rx_full <= 1'b1;
      rx_byte <= rx_inject_byte;
    end
  end

  assign sif.uart_rdata = (sif.uart_addr == 32'h4)  ? {30'b0, rx_full, tx_cnt != 0} :
                          (sif.uart_addr == 32'h10) ? {24'b0, rx_byte} : 32'h0;

  // ---------------- behavioural model: queue of pending bus ops ----------------
  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t        mq[$];
  logic       m_rxv, m_init, m_rr;
  logic [7:0] m_rxd;

  initial begin
    op_t        op;
    logic       e_wr, e_r0, e_r1, n_rxv, n_init, n_rr, g;
    logic [31:0] e_addr, e_wd;
    logic [7:0] n_rxd, d;
    mq.push_back('{1'b1, 32'h0, {30'b0, RXEN, 1'b1}});
    mq.push_back('{1'b1, 32'h8, 32'(DIV)});
    m_rxv = 0; m_rxd = 0; m_init = 0; m_rr = 0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      e_wr = 0; e_addr = 0; e_wd = 0; e_r0 = 0; e_r1 = 0;
      n_rxv = m_rxv; n_rxd = m_rxd; n_init = m_init; n_rr = m_rr;
      if (!rst_n) begin
        mq.delete();
        mq.push_back('{1'b1, 32'h0, {30'b0, RXEN, 1'b1}});
        mq.push_back('{1'b1, 32'h8, 32'(DIV)});
        n_rxv = 0; n_rxd = 0; n_init = 0; n_rr = 0;
      end else begin
        if (m_rxv && sif.rx_ready) n_rxv = 0;
        if (mq.size() != 0) begin
          op = mq.pop_front();
          e_wr = op.wr; e_addr = op.addr; e_wd = op.data;
          if (!op.wr && op.addr == 32'h10) begin n_rxv = 1; n_rxd = rx_byte; end
          if (op.wr && op.addr == 32'h8) n_init = 1;
        end else begin
          e_addr = 32'h4;
          if (RXEN && rx_full && !m_rxv) begin
            mq.push_back('{1'b0, 32'h10, 32'h0});
            mq.push_back('{1'b1, 32'h4, 32'h0});
          end else if (tx_cnt == 0 && (sif.req0_valid || sif.req1_valid)) begin
            g = (sif.req0_valid && sif.req1_valid) ? m_rr : !sif.req0_valid;
            d = g ? sif.req1_data : sif.req0_data;
            if (g) e_r1 = 1; else e_r0 = 1;
            mq.push_back('{1'b1, 32'hC, {24'b0, d}});
            n_rr = !g;
          end
        end
      end
      chk("m_wr_en", sif.uart_wr_en, e_wr);
      chk("m_addr", sif.uart_addr, e_addr);
      chk("m_wdata", sif.uart_wdata, e_wd);
      chk("m_req0_ready", sif.req0_ready, e_r0);
      chk("m_req1_ready", sif.req1_ready, e_r1);
      chk("m_rx_valid", sif.rx_valid, m_rxv);
      chk("m_rx_data", sif.rx_data, m_rxd);
      chk("m_init_done", sif.init_done, m_init);
      m_rxv = n_rxv; m_rxd = n_rxd; m_init = n_init; m_rr = n_rr;
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int which, output bit seen);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if ((which == 0) ? sif.req0_ready : sif.req1_ready) seen = 1;
    end
  endtask

  initial begin
    bit seen;
    int n, base;
    rst_n = 0;
    sif.req0_valid = 0; sif.req0_data = 0;
    sif.req1_valid = 0; sif.req1_data = 0;
    sif.rx_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // 1: init sequence
    @(negedge clk);
    chk("t1_c0_wr", sif.uart_wr_en, 1); chk("t1_c0_addr", sif.uart_addr, 0); chk("t1_c0_data", sif.uart_wdata, 3);
    @(negedge clk);
    chk("t1_c1_wr", sif.uart_wr_en, 1); chk("t1_c1_addr", sif.uart_addr, 8); chk("t1_c1_data", sif.uart_wdata, 434);
    @(negedge clk);
    chk("t1_c2_wr", sif.uart_wr_en, 0); chk("t1_c2_addr", sif.uart_addr, 4); chk("t1_init_done", sif.init_done, 1);

    // 2: single requester, then blocked while the UART is busy
    tick();
    sif.req0_valid = 1; sif.req0_data = 8'h55;
    wait_ready(0, seen);
    chk("t2_grant", seen, 1);
    tick();
    sif.req0_data = 8'h66;
    @(negedge clk);
    chk("t2_tx_wr", sif.uart_wr_en, 1); chk("t2_tx_addr", sif.uart_addr, 32'hC); chk("t2_tx_data", sif.uart_wdata, 32'h55);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (sif.req0_ready) break;
    end
    chk("t2_busy_gap", n, 4);
    tick();
    sif.req0_valid = 0;
    @(negedge clk);
    chk("t2_tx2_data", sif.uart_wdata, 32'h66);

    // 3: both held valid after a fresh reset -> strict alternation from req0
    repeat (6) @(posedge clk);
    #1 rst_n = 0;
    tick();
    rst_n = 1;
    base = tx_log.size();
    sif.req0_valid = 1; sif.req0_data = 8'hA1;
    sif.req1_valid = 1; sif.req1_data = 8'hB2;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (tx_log.size() >= base + 4) seen = 1;
    end
    chk("t3_done", seen, 1);
    tick();
    sif.req0_valid = 0; sif.req1_valid = 0;
    for (int i = 0; i < 4; i++)
      chk("t3_byte", (tx_log.size() > base + i) ? tx_log[base + i] : 8'h00, (i % 2) ? 8'hB2 : 8'hA1);

    // 4: receive with consumer ready
    repeat (6) @(posedge clk);
    #1 sif.rx_ready = 1; rx_inject = 1; rx_inject_byte = 8'h3C;
    tick();
    rx_inject = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!sif.uart_wr_en && sif.uart_addr == 32'h10) seen = 1;
    end
    chk("t4_rx_rd", seen, 1);
    @(negedge clk);
    chk("t4_clr_wr", sif.uart_wr_en, 1); chk("t4_clr_addr", sif.uart_addr, 4); chk("t4_clr_data", sif.uart_wdata, 0);
    chk("t4_rx_valid", sif.rx_valid, 1); chk("t4_rx_data", sif.rx_data, 32'h3C);
    @(negedge clk);
    chk("t4_rx_drop", sif.rx_valid, 0);

    // 4b: consumer stalled, second byte waits in UART and overwrites there
    tick();
    sif.rx_ready = 0; rx_inject = 1; rx_inject_byte = 8'h11;
    tick();
    rx_inject = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sif.rx_valid) seen = 1;
    end
    chk("t4b_hold_valid", seen, 1); chk("t4b_hold_data", sif.rx_data, 32'h11);
    tick();
    rx_inject = 1; rx_inject_byte = 8'h22;
    tick();
    rx_inject = 0;
    repeat (4) @(negedge clk);
    chk("t4b_still_held", sif.rx_data, 32'h11);
    tick();
    sif.rx_ready = 1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (sif.rx_valid && sif.rx_data == 8'h22) seen = 1;
    end
    chk("t4b_second_byte", seen, 1);

    // 5: RX pending and req1 valid in the same POLL
    repeat (4) @(posedge clk);
    #1 rx_inject = 1; rx_inject_byte = 8'h5A;
    tick();
    rx_inject = 0;
    sif.req1_valid = 1; sif.req1_data = 8'hC3;
    @(negedge clk);
    chk("t5_poll_addr", sif.uart_addr, 4); chk("t5_no_grant", sif.req1_ready, 0);
    @(negedge clk);
    chk("t5_rx_rd", sif.uart_addr, 32'h10);
    @(negedge clk);
    chk("t5_rx_clr", sif.uart_addr, 4); chk("t5_rx_clr_wr", sif.uart_wr_en, 1);
    @(negedge clk);
    chk("t5_grant", sif.req1_ready, 1);
    tick();
    sif.req1_valid = 0;
    @(negedge clk);
    chk("t5_tx_data", sif.uart_wdata, 32'hC3);

    // 6: reset during TX_WR
    repeat (6) @(posedge clk);
    #1 sif.req0_valid = 1; sif.req0_data = 8'h77;
    wait_ready(0, seen);
    chk("t6_grant", seen, 1);
    base = tx_log.size();
    tick();
    rst_n = 0; sif.req0_valid = 0;
    @(negedge clk);
    chk("t6_no_wr", sif.uart_wr_en, 0); chk("t6_addr", sif.uart_addr, 0); chk("t6_ready", sif.req0_ready, 0);
    tick();
    rst_n = 1;
    @(negedge clk);
    chk("t6_c0_addr", sif.uart_addr, 0); chk("t6_c0_wr", sif.uart_wr_en, 1);
    @(negedge clk);
    chk("t6_c1_addr", sif.uart_addr, 8); chk("t6_c1_data", sif.uart_wdata, 434);
    chk("t6_no_txdata", tx_log.size(), base);
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
